axi_lite_reg_slave_v2: RTL and testbench
========================================

// Module: axi_lite_reg_slave_v2
// PURPOSE
//  Next-generation AXI4-Lite register slave for NPU configuration space. It decodes
//  AXI4-Lite transactions into single-cycle register-file strobes.
//  - Write path: AW and W are accepted independently and in either order; WSTRB is
//    forwarded to the register file.
//  - Read path: the register-file read latency is a parameter.
//  - Errors: decode, alignment and register-file errors return SLVERR.
//  Sits between the system AXI-Lite interconnect and the NPU CSR bank.
// PARAMETERS
//  DATA_WIDTH   32  data bus width; must be 32 or 64
//  ADDR_WIDTH   32  AXI address width
//  NUM_REGS     64  register count, power of 2; word index = addr[$clog2(NUM_REGS)+AL-1:AL], AL=$clog2(DATA_WIDTH/8)
//  BASE_ADDR    0   byte base of the window, aligned to NUM_REGS*DATA_WIDTH/8
//  RD_LATENCY   1   cycles from reg_rd_en to valid reg_rd_data/reg_rd_err; legal range 1..4
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  s_axil_awaddr   in   ADDR_WIDTH    write address
//  s_axil_awvalid  in   1             write address valid
//  s_axil_awready  out  1             write address ready
//  s_axil_wdata    in   DATA_WIDTH    write data
//  s_axil_wstrb    in   DATA_WIDTH/8  byte strobes
//  s_axil_wvalid   in   1             write data valid
//  s_axil_wready   out  1             write data ready
//  s_axil_bresp    out  2             write response: OKAY=00, SLVERR=10
//  s_axil_bvalid   out  1             write response valid
//  s_axil_bready   in   1             write response ready
//  s_axil_araddr   in   ADDR_WIDTH    read address
//  s_axil_arvalid  in   1             read address valid
//  s_axil_arready  out  1             read address ready
//  s_axil_rdata    out  DATA_WIDTH    read data
//  s_axil_rresp    out  2             read response
//  s_axil_rvalid   out  1             read data valid
//  s_axil_rready   in   1             read data ready
//  reg_wr_en       out  1             single-cycle register write strobe
//  reg_wr_addr     out  $clog2(NUM_REGS)  register word index
//  reg_wr_data     out  DATA_WIDTH    register write data
//  reg_wr_strb     out  DATA_WIDTH/8  byte enables for the register write
//  reg_wr_err      in   1             register file rejects the write (RO/reserved); sampled with reg_wr_en
//  reg_rd_en       out  1             single-cycle register read strobe
//  reg_rd_addr     out  $clog2(NUM_REGS)  register word index
//  reg_rd_data     in   DATA_WIDTH    read data, valid RD_LATENCY cycles after reg_rd_en
//  reg_rd_err      in   1             read error, valid together with reg_rd_data
// BEHAVIOUR
//  Reset: every output is 0, including all readies, while rst is high. Readies are
//   registered and go to 1 on the first clk edge after rst falls. Reset mid-transaction
//   discards held AW/W/AR and any pending response; no reg_*_en pulse occurs afterwards.
//  Write holding: one AW slot and one W slot, each with a full flag.
//   - awready = ~aw_full; wready = ~w_full.
//   - A handshake on a channel sets that channel's full flag; simultaneous AW and W
//     handshakes are legal.
//  Write issue: occurs when aw_full & w_full & ~bvalid.
//   - Both full flags clear in the issue cycle.
//   - Decode error (address outside the window, or unaligned address): no strobe,
//     bresp=SLVERR.
//   - wstrb==0: no strobe, bresp=OKAY.
//   - Otherwise reg_wr_en=1 for exactly one cycle with addr/data/strb;
//     bresp = reg_wr_err ? SLVERR : OKAY.
//  Write response: bvalid is asserted the cycle after issue and held, with bresp stable,
//   until bready. A new AW/W may be captured while B is pending; it issues only after the
//   B handshake. Best case is AW+W at cycle 0, reg_wr_en at cycle 1, bvalid at cycle 2.
//  Read FSM: RD_IDLE -> RD_ISSUE -> RD_WAIT -> RD_RESP -> RD_IDLE.
//   - RD_IDLE: arready=1; AR handshake latches the address and moves to RD_ISSUE.
//   - RD_ISSUE, in range: reg_rd_en=1 for one cycle; a counter loads RD_LATENCY-1; next
//     state RD_WAIT.
//   - RD_ISSUE, decode error: no strobe; rdata=0 and rresp=SLVERR are loaded; next state
//     RD_RESP.
//   - RD_WAIT: the counter decrements. At 0, reg_rd_data and reg_rd_err are captured
//     into rdata/rresp; next state RD_RESP.
//   - RD_RESP: rvalid=1 with rdata/rresp stable until rready, then RD_IDLE.
//   - With RD_LATENCY=1: AR at cycle 0, reg_rd_en at cycle 1, rvalid at cycle 3.
//  The read and write paths are fully independent; simultaneous read and write to the
//   same register is resolved by the register file.
//  Address compare: (addr - BASE_ADDR) < NUM_REGS*DATA_WIDTH/8, computed at ADDR_WIDTH
//   width with no wrap. An addr below BASE_ADDR is a decode error.
// STRUCTURE
//  npu_pkg additions:
//   - axi_resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
//   - AXIL_MAX_RD_LATENCY=4.
//  Sub-module axil_hold_slot (payload register + full flag, ready = ~full); two
//   instances, for AW (addr) and W (data+strb).
//  Read FSM, latency counter and decode logic are inline.
// TESTING
//  1 AW and W in the same cycle, addr=BASE+0x08, data=0xDEADBEEF, strb=0xF -> reg_wr_en
//    at cycle 1, addr=2, bvalid at cycle 2, bresp=OKAY.
//  2 W 3 cycles before AW, strb=0x3 -> no strobe until AW arrives, then reg_wr_strb=0x3;
//    bready held low 5 cycles -> bvalid/bresp stable throughout.
//  3 Read addr=BASE+NUM_REGS*4 (out of range) -> no reg_rd_en, rdata=0, rresp=SLVERR;
//    write to the same addr -> no reg_wr_en, bresp=SLVERR.
//  4 RD_LATENCY=3, read addr=BASE+0x10, reg_rd_data=0x1234 -> reg_rd_en at cycle 1,
//    rvalid at cycle 5, rdata=0x1234; reg_rd_err=1 variant -> rresp=SLVERR.
//  5 Back-to-back writes with bready=1 and concurrent reads -> every write produces
//    exactly one strobe, in order, with no AW/W loss.
//  6 Assert rst while in RD_WAIT and while B is pending -> all outputs 0 immediately;
//    readies high 1 cycle after release; no stray reg_*_en pulses.

Source files
------------

// File: rtl/axi_lite_reg_slave_v2_pkg.sv
// Shared types and constants for the NPU AXI4-Lite register slave.
package axi_lite_reg_slave_v2_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    localparam int AXIL_MAX_RD_LATENCY = 4;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

    function automatic axi_resp_t err_to_resp(input logic err);
        return err ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_reg_slave_v2_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register slave.
interface axi_lite_reg_slave_v2_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave_v2_hold_slot.sv
// One-entry holding slot: captures a payload on handshake and stays full until cleared.
module axil_hold_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);
    logic             full_q, full_d;
    logic             ready_q;
    logic [WIDTH-1:0] data_q;
    logic             take;

    assign take = valid_i & ready_q;

    always_comb begin
        full_d = full_q;
        if (clr_i) full_d = 1'b0;
        if (take)  full_d = 1'b1;
    end

    // Ready is registered so it stays low throughout reset and rises one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ~full_d;
            if (take) data_q <= data_i;
        end
    end

    assign ready_o = ready_q;
    assign full_o  = full_q;
    assign data_o  = data_q;
endmodule

// File: rtl/axi_lite_reg_slave_v2.sv
// AXI4-Lite register slave: decodes AXI-Lite reads/writes into single-cycle register-file strobes.
module axi_lite_reg_slave_v2
    import axi_lite_reg_slave_v2_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    axi_lite_reg_slave_v2_if.slave      s_axil,
    output logic                        reg_wr_en,
    output logic [$clog2(NUM_REGS)-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0]       reg_wr_data,
    output logic [DATA_WIDTH/8-1:0]     reg_wr_strb,
    input  logic                        reg_wr_err,
    output logic                        reg_rd_en,
    output logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
    input  logic [DATA_WIDTH-1:0]       reg_rd_data,
    input  logic                        reg_rd_err
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int AL     = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(AXIL_MAX_RD_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] WINDOW = ADDR_WIDTH'(NUM_REGS * STRB_W);

    // Offset is taken at bus width; addresses below the base are rejected explicitly.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off < WINDOW) && (a[AL-1:0] == '0);
    endfunction

    logic                     aw_full, w_full;
    logic [ADDR_WIDTH-1:0]    aw_addr;
    logic [DATA_WIDTH+STRB_W-1:0] w_payload;
    logic [STRB_W-1:0]        wr_strb;
    logic                     wr_issue, wr_dec_ok;
    logic                     bvalid_q, bvalid_d;
    axi_resp_t                bresp_q, bresp_d;

    assign wr_issue  = aw_full & w_full & ~bvalid_q;
    assign wr_dec_ok = addr_ok(aw_addr);
    assign wr_strb   = w_payload[DATA_WIDTH +: STRB_W];

    axil_hold_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
        .clk(clk), .rst(rst), .valid_i(s_axil.awvalid), .clr_i(wr_issue),
        .data_i(s_axil.awaddr), .ready_o(s_axil.awready), .full_o(aw_full), .data_o(aw_addr)
    );

    axil_hold_slot #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_slot (
        .clk(clk), .rst(rst), .valid_i(s_axil.wvalid), .clr_i(wr_issue),
        .data_i({s_axil.wstrb, s_axil.wdata}), .ready_o(s_axil.wready), .full_o(w_full),
        .data_o(w_payload)
    );

    assign reg_wr_en   = wr_issue & wr_dec_ok & (wr_strb != '0);
    assign reg_wr_addr = aw_addr[IDX_W+AL-1:AL];
    assign reg_wr_data = w_payload[DATA_WIDTH-1:0];
    assign reg_wr_strb = wr_strb;

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wr_issue) begin
            bvalid_d = 1'b1;
            if (!wr_dec_ok)           bresp_d = SLVERR;
            else if (wr_strb == '0)   bresp_d = OKAY;
            else                      bresp_d = err_to_resp(reg_wr_err);
        end else if (bvalid_q && s_axil.bready) begin
            bvalid_d = 1'b0;
        end
    end

    rd_state_t             rd_state_q, rd_state_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    axi_resp_t             rresp_q, rresp_d;
    logic                  arready_q;
    logic                  rd_dec_ok;

    assign rd_dec_ok = addr_ok(ar_addr_q);

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        ar_addr_d  = ar_addr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        reg_rd_en  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (s_axil.arvalid && arready_q) begin
                    ar_addr_d  = s_axil.araddr;
                    rd_state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (rd_dec_ok) begin
                    reg_rd_en  = 1'b1;
                    rd_cnt_d   = CNT_W'(RD_LATENCY - 1);
                    rd_state_d = RD_WAIT;
                end else begin
                    rdata_d    = '0;
                    rresp_d    = SLVERR;
                    rd_state_d = RD_RESP;
                end
            end
            RD_WAIT: begin
                if (rd_cnt_q == '0) begin
                    rdata_d    = reg_rd_data;
                    rresp_d    = err_to_resp(reg_rd_err);
                    rd_state_d = RD_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
            end
            RD_RESP: begin
                if (s_axil.rready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            ar_addr_q  <= '0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            arready_q  <= 1'b0;
        end else begin
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            ar_addr_q  <= ar_addr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            arready_q  <= (rd_state_d == RD_IDLE);
        end
    end

    assign reg_rd_addr    = ar_addr_q[IDX_W+AL-1:AL];
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = (rd_state_q == RD_RESP);
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_reg_slave_v2.sv
// Randomized self-checking bench for axi_lite_reg_slave_v2 with a word-array reference model.
`timescale 1ns/1ps
module tb_axi_lite_reg_slave_v2;
    localparam int          DW       = 32;
    localparam int          AW       = 32;
    localparam int          NR       = 64;
    localparam int          RDL      = 3;
    localparam logic [31:0] BASE     = 32'h4000_1000;
    localparam int          RO_IDX   = 63;
    localparam int          RERR_IDX = 62;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axi_lite_reg_slave_v2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic        reg_wr_en, reg_wr_err, reg_rd_en, reg_rd_err;
    logic [5:0]  reg_wr_addr, reg_rd_addr;
    logic [31:0] reg_wr_data, reg_rd_data;
    logic [3:0]  reg_wr_strb;

    axi_lite_reg_slave_v2 #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BASE), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .rst(rst), .s_axil(bus),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_strb(reg_wr_strb), .reg_wr_err(reg_wr_err),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .reg_rd_err(reg_rd_err)
    );

    // CSR bank stand-in: register 63 is read-only, register 62 flags read errors.
    logic [31:0] rf [NR];
    logic [5:0]  rd_pipe [1:RDL];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) rf[i] <= '0;
            for (int k = 1; k <= RDL; k++) rd_pipe[k] <= '0;
        end else begin
            if (reg_wr_en && !reg_wr_err)
                for (int b = 0; b < 4; b++)
                    if (reg_wr_strb[b]) rf[reg_wr_addr][8*b +: 8] <= reg_wr_data[8*b +: 8];
            rd_pipe[1] <= reg_rd_addr;
            for (int k = 2; k <= RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign reg_rd_data = rf[rd_pipe[RDL]];
    assign reg_rd_err  = (rd_pipe[RDL] == 6'(RERR_IDX));
    assign reg_wr_err  = (reg_wr_addr == 6'(RO_IDX));

    typedef struct { logic [5:0] a; logic [31:0] d; logic [3:0] s; int c; } wr_rec_t;
    wr_rec_t wr_q[$];
    int rd_en_cnt = 0;
    int rd_en_cyc = -1;
    always @(negedge clk) begin
        if (reg_wr_en) wr_q.push_back('{reg_wr_addr, reg_wr_data, reg_wr_strb, cyc});
        if (reg_rd_en) begin
            rd_en_cnt = rd_en_cnt + 1;
            rd_en_cyc = cyc;
        end
    end

    logic [31:0] ref_mem [NR];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic dec_ok(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(NR * 4)) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [5:0] word_idx(input logic [31:0] a);
        return 6'((a - BASE) >> 2);
    endfunction

    task automatic drive_aw(input logic [31:0] a, input int dly, output int hs);
        hs = -1;
        repeat (dly) begin @(posedge clk); #1; end
        bus.awaddr = a; bus.awvalid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (bus.awready) begin hs = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        if (hs < 0) chk("aw_timeout", 0, 1);
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly, output int hs);
        hs = -1;
        repeat (dly) begin @(posedge clk); #1; end
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (bus.wready) begin hs = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        if (hs < 0) chk("w_timeout", 0, 1);
    endtask

    task automatic drive_ar(input logic [31:0] a, output int hs);
        hs = -1;
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (bus.arready) begin hs = cyc; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        if (hs < 0) chk("ar_timeout", 0, 1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        logic ok, exp_s;
        logic [1:0] exp_r;
        logic [5:0] idx;
        int aw_c, w_c, b_c, q0, iss;
        ok    = dec_ok(addr);
        idx   = word_idx(addr);
        exp_s = ok && (strb != 4'h0);
        exp_r = (!ok || (exp_s && idx == 6'(RO_IDX))) ? 2'b10 : 2'b00;
        if (exp_s && idx != 6'(RO_IDX))
            for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        q0 = wr_q.size();
        fork
            drive_aw(addr, aw_dly, aw_c);
            drive_w(data, strb, w_dly, w_c);
        join
        iss = ((aw_c > w_c) ? aw_c : w_c) + 1;
        b_c = -1;
        for (int t = 0; t < 40; t++) begin
            if (bus.bvalid) begin b_c = cyc; break; end
            @(posedge clk); #1;
        end
        if (b_c < 0) chk("b_timeout", 0, 1);
        chk("b_latency", b_c - iss, 1);
        chk("wr_strobes", wr_q.size() - q0, exp_s);
        if (exp_s && wr_q.size() > q0) begin
            chk("wr_addr", wr_q[q0].a, idx);
            chk("wr_data", wr_q[q0].d, data);
            chk("wr_strb", wr_q[q0].s, strb);
            chk("wr_cycle", wr_q[q0].c - iss, 0);
        end
        for (int t = 0; t < b_dly; t++) begin
            chk("b_hold_valid", bus.bvalid, 1);
            chk("b_hold_resp", bus.bresp, exp_r);
            @(posedge clk); #1;
        end
        chk("bresp", bus.bresp, exp_r);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        chk("b_done", bus.bvalid, 0);
        $display("WR addr=%08h data=%08h strb=%h resp=%0d strobe=%0d", addr, data, strb, exp_r, exp_s);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly);
        logic ok;
        logic [31:0] exp_d;
        logic [1:0] exp_r;
        logic [5:0] idx;
        int ar_c, r_c, n0;
        ok    = dec_ok(addr);
        idx   = word_idx(addr);
        exp_d = ok ? ref_mem[idx] : 32'h0;
        exp_r = (!ok || idx == 6'(RERR_IDX)) ? 2'b10 : 2'b00;
        n0 = rd_en_cnt;
        drive_ar(addr, ar_c);
        r_c = -1;
        for (int t = 0; t < 40; t++) begin
            if (bus.rvalid) begin r_c = cyc; break; end
            @(posedge clk); #1;
        end
        if (r_c < 0) chk("r_timeout", 0, 1);
        chk("r_latency", r_c - ar_c, ok ? 2 + RDL : 2);
        chk("rd_en_count", rd_en_cnt - n0, ok ? 1 : 0);
        if (ok) chk("rd_en_cycle", rd_en_cyc - ar_c, 1);
        for (int t = 0; t < r_dly; t++) begin
            chk("r_hold_valid", bus.rvalid, 1);
            chk("r_hold_data", {bus.rresp, bus.rdata}, {exp_r, exp_d});
            @(posedge clk); #1;
        end
        chk("rdata", bus.rdata, exp_d);
        chk("rresp", bus.rresp, exp_r);
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        chk("r_done", bus.rvalid, 0);
        $display("RD addr=%08h data=%08h resp=%0d", addr, exp_d, exp_r);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                             reg_wr_en, reg_rd_en}, 0);
        chk({tag, "_fields"}, {bus.bresp, bus.rresp, reg_wr_addr, reg_rd_addr, reg_wr_strb}, 0);
        chk({tag, "_data"}, {bus.rdata, reg_wr_data}, 0);
    endtask

    task automatic stream_test();
        localparam int N = 12;
        logic [31:0] wa [N];
        logic [31:0] wd [N];
        logic [3:0]  ws [N];
        int q0, nb;
        for (int i = 0; i < N; i++) begin
            wa[i] = BASE + 32'($urandom_range(0, 31) * 4);
            wd[i] = $urandom;
            ws[i] = 4'($urandom_range(1, 15));
            for (int b = 0; b < 4; b++)
                if (ws[i][b]) ref_mem[word_idx(wa[i])][8*b +: 8] = wd[i][8*b +: 8];
        end
        q0 = wr_q.size();
        nb = 0;
        fork
            begin
                logic got;
                bus.awvalid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    bus.awaddr = wa[i];
                    got = 1'b0;
                    for (int t = 0; t < 40; t++) begin
                        if (bus.awready) begin got = 1'b1; break; end
                        @(posedge clk); #1;
                    end
                    if (!got) chk("s_aw_timeout", 0, 1);
                    @(posedge clk); #1;
                end
                bus.awvalid = 1'b0;
            end
            begin
                logic got;
                bus.wvalid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    bus.wdata = wd[i]; bus.wstrb = ws[i];
                    got = 1'b0;
                    for (int t = 0; t < 40; t++) begin
                        if (bus.wready) begin got = 1'b1; break; end
                        @(posedge clk); #1;
                    end
                    if (!got) chk("s_w_timeout", 0, 1);
                    @(posedge clk); #1;
                end
                bus.wvalid = 1'b0;
            end
            begin
                bus.bready = 1'b1;
                for (int t = 0; t < 600; t++) begin
                    if (bus.bvalid) begin
                        chk("s_bresp", bus.bresp, 0);
                        nb++;
                    end
                    @(posedge clk); #1;
                    if (nb == N) break;
                end
                bus.bready = 1'b0;
            end
            begin
                for (int j = 0; j < 5; j++)
                    axi_read(BASE + 32'($urandom_range(32, 61) * 4), $urandom_range(0, 1));
            end
        join
        chk("s_bcount", nb, N);
        chk("s_strobes", wr_q.size() - q0, N);
        for (int i = 0; i < N; i++) begin
            if (q0 + i < wr_q.size()) begin
                chk("s_wr_addr", wr_q[q0+i].a, word_idx(wa[i]));
                chk("s_wr_data", wr_q[q0+i].d, wd[i]);
                chk("s_wr_strb", wr_q[q0+i].s, ws[i]);
                $display("WR-STREAM %0d addr=%08h data=%08h strb=%h", i, wa[i], wd[i], ws[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c1, c2, c3, n_wr, n_rd, kind, idx;
        logic [31:0] a;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        for (int i = 0; i < NR; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // Simultaneous AW/W; W leading AW with a slow bready.
        axi_write(BASE + 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'h0C, 32'h5566_7788, 4'h3, 3, 0, 5);
        axi_read(BASE + 32'h08, 0);
        axi_read(BASE + 32'h0C, 1);

        // Out-of-window, below-base and unaligned accesses.
        axi_read(BASE + 32'(NR * 4), 0);
        axi_write(BASE + 32'(NR * 4), 32'h1111_2222, 4'hF, 0, 0, 0);
        axi_read(BASE - 32'h4, 0);
        axi_write(BASE + 32'h11, 32'h3333_4444, 4'hF, 1, 0, 0);
        axi_write(BASE + 32'h14, 32'h9999_0000, 4'h0, 0, 1, 0);

        // Latency-3 read path and error paths of the register file.
        axi_write(BASE + 32'h10, 32'h0000_1234, 4'hF, 0, 0, 0);
        axi_read(BASE + 32'h10, 2);
        axi_write(BASE + 32'(RERR_IDX * 4), 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        axi_read(BASE + 32'(RERR_IDX * 4), 0);
        axi_write(BASE + 32'(RO_IDX * 4), 32'hBAD0_BAD0, 4'hF, 0, 0, 1);
        axi_read(BASE + 32'(RO_IDX * 4), 0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            idx  = (kind == 9) ? $urandom_range(RERR_IDX, RO_IDX) : $urandom_range(0, NR - 1);
            case (kind)
                0: a = BASE - 32'(4 * $urandom_range(1, 4));
                1: a = BASE + 32'(NR * 4) + 32'(4 * $urandom_range(0, 3));
                2: a = BASE + 32'(idx * 4) + 32'($urandom_range(1, 3));
                default: a = BASE + 32'(idx * 4);
            endcase
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2));
        end

        stream_test();

        // Reset while the read waits on the register file and a B response is pending.
        fork
            drive_aw(BASE + 32'h20, 0, c1);
            drive_w(32'hA5A5_0F0F, 4'hF, 0, c2);
        join
        drive_ar(BASE + 32'h24, c3);
        @(posedge clk); #1;
        chk("pre_rst_bvalid", bus.bvalid, 1);
        chk("pre_rst_rvalid", bus.rvalid, 0);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        n_wr = wr_q.size();
        n_rd = rd_en_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_mid_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_wr_strobes", wr_q.size() - n_wr, 0);
        chk("post_rst_rd_strobes", rd_en_cnt - n_rd, 0);
        chk("post_rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        for (int i = 0; i < NR; i++) ref_mem[i] = '0;

        axi_read(BASE + 32'h20, 0);
        axi_write(BASE + 32'h24, 32'h0BAD_CAFE, 4'hC, 0, 2, 0);
        axi_read(BASE + 32'h24, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
